// File: rtl/cdb_arbiter_pkg.sv
// Shared defaults and word types for the common data bus: the arbiter,
// the result listeners and the register file all agree on these widths.
package cdb_arbiter_pkg;

  localparam int unsigned CdbNumReq    = 4;
  localparam int unsigned CdbDataWidth = 4;
  localparam int unsigned CdbTagWidth  = 4;

  typedef logic [CdbTagWidth-1:0]  cdb_tag_t;
  typedef logic [CdbDataWidth-1:0] cdb_data_t;

  // Explicit wrap so non-power-of-two requester counts work.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned num);
    if (idx + 1 >= num) return 0;
    return idx + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side request bus plus the registered CDB broadcast it feeds.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int unsigned NUM_REQ       = CdbNumReq,
  parameter int unsigned DATA_WIDTH    = CdbDataWidth,
  parameter int unsigned CDB_TAG_WIDTH = CdbTagWidth
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*CDB_TAG_WIDTH-1:0] req_tag;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             cdb_hold;
  logic                             cdb_out_valid;
  logic [CDB_TAG_WIDTH-1:0]         cdb_out_tag;
  logic [DATA_WIDTH-1:0]            cdb_out_data;
  logic [IdxW-1:0]                  grant_idx;

  modport master (
    output req_valid, req_tag, req_data, cdb_hold,
    input  req_ready, cdb_out_valid, cdb_out_tag, cdb_out_data, grant_idx
  );

  modport slave (
    input  req_valid, req_tag, req_data, cdb_hold,
    output req_ready, cdb_out_valid, cdb_out_tag, cdb_out_data, grant_idx
  );

endinterface

// File: rtl/cdb_arbiter_rr_priority_picker.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping modulo NumReq. Returns a one-hot grant and its index.
module cdb_arbiter_rr_priority_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW:0] pos;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = 0; off < int'(NumReq); off++) begin
      // One spare bit holds ptr+off before the wrap back into range.
      pos = {1'b0, ptr_i} + (IdxW+1)'(off);
      if (pos >= (IdxW+1)'(NumReq)) pos = pos - (IdxW+1)'(NumReq);
      if (!found && req_i[pos[IdxW-1:0]]) begin
        found                  = 1'b1;
        gnt_o[pos[IdxW-1:0]]   = 1'b1;
        idx_o                  = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one producer per cycle
// and broadcasts its tag/data on a registered output one cycle later.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int unsigned NUM_REQ       = CdbNumReq,
  parameter int unsigned DATA_WIDTH    = CdbDataWidth,
  parameter int unsigned CDB_TAG_WIDTH = CdbTagWidth
) (
  input  logic           clk,
  input  logic           rst,
  cdb_arbiter_if.slave   bus
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       pick_gnt;
  logic [NUM_REQ-1:0]       ready;
  logic [IdxW-1:0]          pick_idx;
  logic                     xfer;
  logic [CDB_TAG_WIDTH-1:0] tag_sel;
  logic [DATA_WIDTH-1:0]    data_sel;

  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [IdxW-1:0]          gidx_q, gidx_d;
  logic                     valid_q, valid_d;
  logic [CDB_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;

  cdb_arbiter_rr_priority_picker #(
    .NumReq (NUM_REQ),
    .IdxW   (IdxW)
  ) u_picker (
    .req_i  (bus.req_valid),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign ready = (rst || bus.cdb_hold) ? '0 : pick_gnt;
  assign xfer  = |ready;

  // AND-OR mux driven by the one-hot grant.
  always_comb begin
    tag_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (pick_gnt[i]) begin
        tag_sel  = tag_sel  | bus.req_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
        data_sel = data_sel | bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    tag_d   = tag_q;
    data_d  = data_q;
    valid_d = xfer;
    if (xfer) begin
      ptr_d  = IdxW'(rr_next(int'(pick_idx), NUM_REQ));
      gidx_d = pick_idx;
      tag_d  = tag_sel;
      data_d = data_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      gidx_q  <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.cdb_out_valid = valid_q;
  assign bus.cdb_out_tag   = tag_q;
  assign bus.cdb_out_data  = data_q;
  assign bus.grant_idx     = gidx_q;

endmodule
